// File: rtl/ifft_seq.sv
// ifft_seq: sequential radix-2 DIT inverse FFT, one shared butterfly.
// Loads N complex bins (stored bit-reversed), runs log2(N) in-place stages
// of N/2 butterflies each (one per cycle), then streams N time samples out
// in natural order. Every butterfly halves its outputs, so the result is
// scaled by 1/N overall.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input bin handshake, in_re/in_im bin data
//   out_valid/out_ready output sample handshake, out_re/out_im sample data
//   out_last            high on sample N-1
//   busy                high while computing or unloading
module ifft_seq #(
    parameter int N    = 8,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last,
    output logic         busy
);
    localparam int  LOGN = $clog2(N);
    localparam int  PW   = 2 * W + 1;
    localparam real PI   = 3.14159265358979323846;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    typedef logic signed [PW-1:0] prod_t;

    state_t                 state_q, state_d;
    logic [LOGN-1:0]        idx_q, idx_d;     // load / unload sample index
    logic [LOGN-1:0]        stage_q, stage_d;
    logic [LOGN-1:0]        bfly_q, bfly_d;
    logic signed [W-1:0]    xr_q [N];
    logic signed [W-1:0]    xr_d [N];
    logic signed [W-1:0]    xi_q [N];
    logic signed [W-1:0]    xi_d [N];

    // Twiddle table w(t) = cos(2*pi*t/N) + j*sin(2*pi*t/N), rounded to
    // nearest. Only t < N/2 is ever addressed; the table is sized N so the
    // LOGN-bit twiddle index needs no narrowing, and the upper half is
    // dead logic.
    logic signed [W-1:0]    tw_re [N];
    logic signed [W-1:0]    tw_im [N];

    for (genvar t = 0; t < N; t++) begin : g_tw
        localparam real C  = $cos(2.0 * PI * t / N) * real'(1 << FRAC);
        localparam real S  = $sin(2.0 * PI * t / N) * real'(1 << FRAC);
        localparam int  CI = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
        localparam int  SI = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
        assign tw_re[t] = W'(CI);
        assign tw_im[t] = W'(SI);
    end

    // Butterfly addressing for (stage, j)
    logic [LOGN-1:0]        half, pos, grp, a_idx, b_idx, t_idx, rev_idx;
    logic signed [W-1:0]    ar, ai, br, bi, wr, wi, pr, pim;
    prod_t                  pr_full, pi_full;
    logic signed [W:0]      sum_r, sum_i, dif_r, dif_i;

    always_comb begin
        half  = LOGN'(1) << stage_q;
        pos   = bfly_q & (half - 1'b1);
        grp   = bfly_q >> stage_q;
        a_idx = (grp << (stage_q + 1'b1)) | pos;
        b_idx = a_idx + half;
        t_idx = pos << (LOGN'(LOGN - 1) - stage_q);

        ar = xr_q[a_idx];
        ai = xi_q[a_idx];
        br = xr_q[b_idx];
        bi = xi_q[b_idx];
        wr = tw_re[t_idx];
        wi = tw_im[t_idx];

        // Full-precision complex multiply, floor-shift back to Q format
        pr_full = prod_t'(wr) * prod_t'(br) - prod_t'(wi) * prod_t'(bi);
        pi_full = prod_t'(wr) * prod_t'(bi) + prod_t'(wi) * prod_t'(br);
        pr  = W'(pr_full >>> FRAC);
        pim = W'(pi_full >>> FRAC);

        // One guard bit so the sum cannot overflow before the halving
        sum_r = {ar[W-1], ar} + {pr[W-1], pr};
        sum_i = {ai[W-1], ai} + {pim[W-1], pim};
        dif_r = {ar[W-1], ar} - {pr[W-1], pr};
        dif_i = {ai[W-1], ai} - {pim[W-1], pim};

        rev_idx = '0;
        for (int i = 0; i < LOGN; i++) begin
            rev_idx[i] = idx_q[LOGN-1-i];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        xr_d      = xr_q;
        xi_d      = xi_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_re    = '0;
        out_im    = '0;
        busy      = 1'b1;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    xr_d[rev_idx] = in_re;
                    xi_d[rev_idx] = in_im;
                    idx_d         = idx_q + 1'b1;
                    if (idx_q == LOGN'(N - 1)) begin
                        idx_d   = '0;
                        stage_d = '0;
                        bfly_d  = '0;
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                xr_d[a_idx] = W'(sum_r >>> 1);
                xi_d[a_idx] = W'(sum_i >>> 1);
                xr_d[b_idx] = W'(dif_r >>> 1);
                xi_d[b_idx] = W'(dif_i >>> 1);
                bfly_d      = bfly_q + 1'b1;
                if (bfly_q == LOGN'(N / 2 - 1)) begin
                    bfly_d  = '0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == LOGN'(LOGN - 1)) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_re    = xr_q[idx_q];
                out_im    = xi_q[idx_q];
                out_last  = (idx_q == LOGN'(N - 1));
                if (out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (out_last) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            for (int i = 0; i < N; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
        end
    end
endmodule

// File: tb/tb_ifft_seq.sv
// Bench for ifft_seq: driver loads frames and pushes the expected time
// samples (direct inverse DFT in real arithmetic, scaled by 1/N) into a
// scoreboard; a negedge monitor pops and compares on each output handshake
// and checks stall stability and load/unload exclusion.
module tb_ifft_seq;
    localparam int  N    = 8;
    localparam int  W    = 32;
    localparam int  FRAC = 16;
    localparam int  LOGN = 3;
    localparam int  S    = LOGN * N / 2;
    localparam real PI   = 3.14159265358979323846;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         in_ready, out_valid, out_last, busy;
    logic [W-1:0] out_re, out_im;

    typedef struct {
        real re;
        real im;
        bit  last;
        real tol;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rdy_mode = 0;
    int   rdy_cnt  = 0;
    int   inflight = 0;
    int   hs_cnt   = 0;

    ifft_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_r(input string nm, input int act, input real exp, input real tol);
        real d;
        n_tests++;
        d = real'(act) - exp;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %f (tol %f)", nm, act, exp, tol);
        end
    endtask

    // Reference: x[n] = (1/N) * sum_k X[k] * e^{+j*2*pi*k*n/N}
    task automatic push_frame(input int xr[N], input int xi[N], input real tol);
        for (int n = 0; n < N; n++) begin
            real  sr, si, ang;
            exp_t e;
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < N; k++) begin
                ang = 2.0 * PI * real'(k * n) / real'(N);
                sr += real'(xr[k]) * $cos(ang) - real'(xi[k]) * $sin(ang);
                si += real'(xr[k]) * $sin(ang) + real'(xi[k]) * $cos(ang);
            end
            e.re   = sr / real'(N);
            e.im   = si / real'(N);
            e.last = (n == N - 1);
            e.tol  = tol;
            sb.push_back(e);
        end
    endtask

    // Called and returns at posedge+#1
    task automatic load_frame(input int xr[N], input int xi[N], input bit gaps);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < N && guard < 3000) begin
            in_valid = !(gaps && $urandom_range(0, 2) == 0);
            in_re    = xr[k];
            in_im    = xi[k];
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < N) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: accepted %0d expected %0d", k, N);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || busy) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d samples outstanding expected 0", sb.size());
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = toggle with a 5-cycle stall,
    // 2 = random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                if (out_valid) rdy_cnt++;
                out_ready = (rdy_cnt >= 6 && rdy_cnt <= 10) ? 1'b0 : rdy_cnt[0];
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor
    bit           stall = 1'b0;
    logic [W-1:0] st_re, st_im;
    logic         st_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            inflight = 0;
            hs_cnt   = 0;
            stall    = 1'b0;
        end else begin
            if (busy) chk("in_ready_while_busy", in_ready, 0);
            if (stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_re_stable", out_re, st_re);
                chk("stall_im_stable", out_im, st_im);
                chk("stall_last_stable", out_last, st_last);
            end
            if (in_valid && in_ready) begin
                chk("accept_before_unload_done", inflight, 0);
                hs_cnt++;
                if (hs_cnt == N) begin
                    hs_cnt = 0;
                    inflight++;
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got re %0d with empty scoreboard", $signed(out_re));
                end else begin
                    e = sb.pop_front();
                    chk_r("out_re", $signed(out_re), e.re, e.tol);
                    chk_r("out_im", $signed(out_im), e.im, e.tol);
                    chk("out_last", out_last, e.last);
                end
                if (out_last) inflight--;
            end
            stall   = out_valid && !out_ready;
            st_re   = out_re;
            st_im   = out_im;
            st_last = out_last;
        end
    end

    initial begin
        int imp_r[N], dc_r[N], sb_r[N], zero[N], rr[N], ri[N];
        int lat;
        for (int i = 0; i < N; i++) begin
            zero[i]  = 0;
            imp_r[i] = 0;
            dc_r[i]  = 32'h0001_0000;
            sb_r[i]  = 0;
        end
        imp_r[0] = 32'h0001_0000;
        sb_r[1]  = 32'h0008_0000;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse: exact 0x2000 everywhere; first valid one cycle after
        // edge t+S, i.e. seen S edges after the last load edge
        rdy_mode = 0;
        push_frame(imp_r, zero, 0.0);
        load_frame(imp_r, zero, 1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_valid_latency", lat, S);
        drain();

        // DC bins
        push_frame(dc_r, zero, 4.0);
        load_frame(dc_r, zero, 1'b0);
        drain();

        // Single bin: out[n] = e^{j*2*pi*n/8}
        push_frame(sb_r, zero, 4.0);
        load_frame(sb_r, zero, 1'b0);
        drain();

        // Backpressure with the same frame
        rdy_mode = 1;
        rdy_cnt  = 0;
        push_frame(sb_r, zero, 4.0);
        load_frame(sb_r, zero, 1'b0);
        drain();

        // Random frames, random gaps and random out_ready
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                rr[i] = int'($urandom_range(0, 262144)) - 131072;
                ri[i] = int'($urandom_range(0, 262144)) - 131072;
            end
            push_frame(rr, ri, 4.0);
            load_frame(rr, ri, 1'b1);
        end
        drain();

        // Reset five cycles into COMPUTE aborts the frame
        rdy_mode = 0;
        load_frame(sb_r, zero, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        rst = 1'b0;
        push_frame(imp_r, zero, 0.0);
        load_frame(imp_r, zero, 1'b0);
        drain();

        // Back-to-back frames with input gaps
        rdy_mode = 2;
        push_frame(imp_r, zero, 0.0);
        load_frame(imp_r, zero, 1'b1);
        push_frame(dc_r, zero, 4.0);
        load_frame(dc_r, zero, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
